rx_ds_char: RTL
===============

// Module: rx_ds_char
// PURPOSE
//  Parametrised DS-link receiver: synchronises raw data/strobe pins, recovers bits by
//  single-edge DS decoding, frames SpaceWire-style characters, checks parity/escapes.
//  Successor to the 2-bit DS front end: adds framing, NULL hunt, time-codes, disconnect
//  and glitch detection. Sits between the LVDS pins and the link state machine.
// PARAMETERS
//  SYNC_STAGES  2   flops in d/s synchroniser (>=2)
//  DISC_CYCLES  64  rxClk cycles without a bit edge (in RUN) before disconnect
//  CW  $clog2(DISC_CYCLES+1)  disconnect counter width (derived localparam)
// PORTS
//  rxClk      in   1  receive clock, >=3x bit rate
//  rxResetN   in   1  asynchronous, active-low reset
//  d          in   1  raw DS data pin
//  s          in   1  raw DS strobe pin
//  charValid  out  1  one-cycle strobe: charData holds a data/EOP/EEP N-char
//  charData   out  9  [8]=0: data byte; [8]=1: 0x100 EOP, 0x101 EEP
//  gotNull    out  1  one-cycle pulse per NULL (ESC+FCT)
//  gotFct     out  1  one-cycle pulse per standalone FCT
//  gotTime    out  1  one-cycle pulse, timeCode valid
//  timeCode   out  8  time-code byte, held until next time-code
//  errParity  out  1  one-cycle pulse, parity fail
//  errEsc     out  1  one-cycle pulse, ESC followed by ESC/EOP/EEP
//  errDisc    out  1  one-cycle pulse, disconnect timeout
//  errGlitch  out  1  one-cycle pulse, d and s toggled in same sample
//  running    out  1  high in RUN state
// BEHAVIOUR
//  - Reset: all outputs 0, state HUNT, prev sample {d,s}=00, counters 0.
//  - Bit recovery on synced pair: exactly one of d/s changed vs prev -> bit = synced d.
//    Both changed -> glitch. No change -> no bit.
//  - Framing, bits in wire order: P, C, then 8 data bits LSB first (C=0) or 2 ctrl bits
//    (C=1), ctrl code = first|second<<1: 0 FCT, 1 EOP, 2 EEP, 3 ESC.
//  - Parity: data/ctrl bits of previous char + P + C of current char has odd count of ones.
//  - HUNT: bits shift into 7-bit window; match on last 7 bits 1,1,1,0,1,0,0 (ESC tail,
//    FCT with P=0) -> gotNull, enter RUN, parity history = FCT bits (0,0). Glitch in HUNT
//    clears the window silently; no disconnect counting in HUNT.
//  - RUN: bit counter selects P/C/payload; char completes on 4th (ctrl) or 10th (data) bit.
//    Parity checked at C bit; fail -> errParity, no char output, -> HUNT.
//  - Completion: FCT -> gotFct (or gotNull if ESC pending); EOP/EEP -> charValid; data ->
//    charValid, or gotTime+timeCode if ESC pending; ESC with ESC pending, or EOP/EEP
//    after ESC -> errEsc, -> HUNT. ESC sets pending, no output.
//  - Latency: output pulse in the cycle after the final bit edge is seen at synchroniser
//    output; pin-to-output = SYNC_STAGES+2 cycles.
//  - Disconnect: RUN counter cleared on every bit edge; reaching DISC_CYCLES -> errDisc,
//    -> HUNT. Counter saturates, never wraps.
//  - Glitch in RUN -> errGlitch, -> HUNT; partial char discarded.
//  - Only one error pulse per cycle; priority glitch > disconnect > parity > escape.
//  - Reset asserted mid-char: immediate return to reset values; no pulses on release.
// TESTING
//  Stimulus encodes bits DS-style: d=bit, s toggles when bit equals previous; 4 clk/bit.
//  1 Garbage bits, then NULL, FCT -> gotNull once, gotFct once, running=1, no errors.
//  2 After NULL: data 0xA5, EOP, EEP -> charValid x3, charData 0x0A5, 0x100, 0x101.
//  3 After NULL: ESC + data 0x3F -> gotTime, timeCode=0x3F, charValid stays 0.
//  4 Data char with P inverted -> errParity 1 cycle, running=0, no charValid.
//  5 ESC ESC -> errEsc; hold pins DISC_CYCLES after NULL -> errDisc at exact cycle;
//    flip d and s together -> errGlitch.
//  6 rxResetN low mid data char, release, resend NULL+0x5A -> only gotNull, 0x05A.

Source files
------------

// File: rtl/rx_ds_char.sv
// DS-link character receiver: pin synchroniser, single-edge DS bit recovery,
// NULL hunt, character framing with parity/escape checks and disconnect detection.
module rx_ds_char #(
  parameter int SYNC_STAGES = 2,
  parameter int DISC_CYCLES = 64
) (
  input  logic       rxClk,
  input  logic       rxResetN,
  input  logic       d,
  input  logic       s,
  output logic       charValid,
  output logic [8:0] charData,
  output logic       gotNull,
  output logic       gotFct,
  output logic       gotTime,
  output logic [7:0] timeCode,
  output logic       errParity,
  output logic       errEsc,
  output logic       errDisc,
  output logic       errGlitch,
  output logic       running
);

  localparam int CW = $clog2(DISC_CYCLES + 1);
  localparam logic [CW-1:0] DISC_MAX = CW'(DISC_CYCLES);
  // ESC tail (1,1,1) followed by an FCT sent with P=0 (0,1,0,0), oldest bit first
  localparam logic [6:0] NULL_PAT = 7'b1110100;

  typedef enum logic [0:0] {ST_HUNT, ST_RUN} state_e;

  // synchroniser and bit-recovery stage
  logic [SYNC_STAGES-1:0] sync_d_q, sync_d_d;
  logic [SYNC_STAGES-1:0] sync_s_q, sync_s_d;
  logic [1:0]             prev_q, prev_d;
  logic                   ev_val_q, ev_val_d;
  logic                   ev_glitch_q, ev_glitch_d;
  logic                   ev_bit_q, ev_bit_d;
  logic [1:0]             samp, chg;

  // framing state
  state_e          state_q, state_d;
  logic [6:0]      win_q, win_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            p_q, p_d;
  logic            ctrl_q, ctrl_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_acc_q, par_acc_d;
  logic            par_hist_q, par_hist_d;
  logic            esc_q, esc_d;
  logic [CW-1:0]   disc_cnt_q, disc_cnt_d;

  // registered outputs
  logic            char_valid_q, char_valid_d;
  logic [8:0]      char_data_q, char_data_d;
  logic            got_null_q, got_null_d;
  logic            got_fct_q, got_fct_d;
  logic            got_time_q, got_time_d;
  logic [7:0]      time_code_q, time_code_d;
  logic            err_parity_q, err_parity_d;
  logic            err_esc_q, err_esc_d;
  logic            err_disc_q, err_disc_d;
  logic            err_glitch_q, err_glitch_d;
  logic            running_q, running_d;

  logic [6:0]      win_nxt;
  logic [1:0]      code;
  logic [7:0]      data_byte;
  logic            go_hunt;
  logic            done_ctrl, done_data;

  always_comb begin
    sync_d_d    = {sync_d_q[SYNC_STAGES-2:0], d};
    sync_s_d    = {sync_s_q[SYNC_STAGES-2:0], s};
    samp        = {sync_d_q[SYNC_STAGES-1], sync_s_q[SYNC_STAGES-1]};
    chg         = samp ^ prev_q;
    prev_d      = samp;
    ev_val_d    = chg[1] ^ chg[0];
    ev_glitch_d = chg[1] & chg[0];
    ev_bit_d    = samp[1];
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    bit_cnt_d    = bit_cnt_q;
    p_d          = p_q;
    ctrl_d       = ctrl_q;
    sh_d         = sh_q;
    par_acc_d    = par_acc_q;
    par_hist_d   = par_hist_q;
    esc_d        = esc_q;
    disc_cnt_d   = disc_cnt_q;
    char_valid_d = 1'b0;
    char_data_d  = char_data_q;
    got_null_d   = 1'b0;
    got_fct_d    = 1'b0;
    got_time_d   = 1'b0;
    time_code_d  = time_code_q;
    err_parity_d = 1'b0;
    err_esc_d    = 1'b0;
    err_disc_d   = 1'b0;
    err_glitch_d = 1'b0;
    go_hunt      = 1'b0;
    done_ctrl    = 1'b0;
    done_data    = 1'b0;
    win_nxt      = {win_q[5:0], ev_bit_q};
    code         = {ev_bit_q, sh_q[7]};
    data_byte    = {ev_bit_q, sh_q[7:1]};

    case (state_q)
      ST_HUNT: begin
        disc_cnt_d = '0;
        if (ev_glitch_q) begin
          win_d = '0;
        end else if (ev_val_q) begin
          win_d = win_nxt;
          if (win_nxt == NULL_PAT) begin
            got_null_d = 1'b1;
            state_d    = ST_RUN;
            par_hist_d = 1'b0;
            bit_cnt_d  = '0;
            esc_d      = 1'b0;
            win_d      = '0;
          end
        end
      end
      default: begin
        if (ev_glitch_q) begin
          err_glitch_d = 1'b1;
          go_hunt      = 1'b1;
        end else if (!ev_val_q) begin
          disc_cnt_d = (disc_cnt_q == DISC_MAX) ? disc_cnt_q : disc_cnt_q + CW'(1);
          if (disc_cnt_d == DISC_MAX) begin
            err_disc_d = 1'b1;
            go_hunt    = 1'b1;
          end
        end else begin
          disc_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          case (bit_cnt_q)
            4'd0: p_d = ev_bit_q;
            4'd1: begin
              // previous payload + P + C must hold an odd number of ones
              if ((par_hist_q ^ p_q ^ ev_bit_q) == 1'b0) begin
                err_parity_d = 1'b1;
                go_hunt      = 1'b1;
              end else begin
                ctrl_d    = ev_bit_q;
                par_acc_d = 1'b0;
              end
            end
            default: begin
              sh_d      = {ev_bit_q, sh_q[7:1]};
              par_acc_d = par_acc_q ^ ev_bit_q;
              done_ctrl = ctrl_q && (bit_cnt_q == 4'd3);
              done_data = !ctrl_q && (bit_cnt_q == 4'd9);
            end
          endcase

          if (done_ctrl || done_data) begin
            bit_cnt_d  = '0;
            par_hist_d = par_acc_q ^ ev_bit_q;
          end

          if (done_ctrl) begin
            case (code)
              2'd0: begin
                got_null_d = esc_q;
                got_fct_d  = !esc_q;
                esc_d      = 1'b0;
              end
              2'd3: begin
                if (esc_q) begin
                  err_esc_d = 1'b1;
                  go_hunt   = 1'b1;
                end else begin
                  esc_d = 1'b1;
                end
              end
              default: begin
                if (esc_q) begin
                  err_esc_d = 1'b1;
                  go_hunt   = 1'b1;
                end else begin
                  char_valid_d = 1'b1;
                  char_data_d  = {8'h80, code == 2'd2};
                end
              end
            endcase
          end

          if (done_data) begin
            if (esc_q) begin
              got_time_d  = 1'b1;
              time_code_d = data_byte;
              esc_d       = 1'b0;
            end else begin
              char_valid_d = 1'b1;
              char_data_d  = {1'b0, data_byte};
            end
          end
        end
      end
    endcase

    if (go_hunt) begin
      state_d    = ST_HUNT;
      win_d      = '0;
      bit_cnt_d  = '0;
      esc_d      = 1'b0;
      disc_cnt_d = '0;
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge rxClk or negedge rxResetN) begin
    if (!rxResetN) begin
      sync_d_q     <= '0;
      sync_s_q     <= '0;
      prev_q       <= '0;
      ev_val_q     <= 1'b0;
      ev_glitch_q  <= 1'b0;
      ev_bit_q     <= 1'b0;
      state_q      <= ST_HUNT;
      win_q        <= '0;
      bit_cnt_q    <= '0;
      p_q          <= 1'b0;
      ctrl_q       <= 1'b0;
      sh_q         <= '0;
      par_acc_q    <= 1'b0;
      par_hist_q   <= 1'b0;
      esc_q        <= 1'b0;
      disc_cnt_q   <= '0;
      char_valid_q <= 1'b0;
      char_data_q  <= '0;
      got_null_q   <= 1'b0;
      got_fct_q    <= 1'b0;
      got_time_q   <= 1'b0;
      time_code_q  <= '0;
      err_parity_q <= 1'b0;
      err_esc_q    <= 1'b0;
      err_disc_q   <= 1'b0;
      err_glitch_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      sync_d_q     <= sync_d_d;
      sync_s_q     <= sync_s_d;
      prev_q       <= prev_d;
      ev_val_q     <= ev_val_d;
      ev_glitch_q  <= ev_glitch_d;
      ev_bit_q     <= ev_bit_d;
      state_q      <= state_d;
      win_q        <= win_d;
      bit_cnt_q    <= bit_cnt_d;
      p_q          <= p_d;
      ctrl_q       <= ctrl_d;
      sh_q         <= sh_d;
      par_acc_q    <= par_acc_d;
      par_hist_q   <= par_hist_d;
      esc_q        <= esc_d;
      disc_cnt_q   <= disc_cnt_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      got_null_q   <= got_null_d;
      got_fct_q    <= got_fct_d;
      got_time_q   <= got_time_d;
      time_code_q  <= time_code_d;
      err_parity_q <= err_parity_d;
      err_esc_q    <= err_esc_d;
      err_disc_q   <= err_disc_d;
      err_glitch_q <= err_glitch_d;
      running_q    <= running_d;
    end
  end

  assign charValid = char_valid_q;
  assign charData  = char_data_q;
  assign gotNull   = got_null_q;
  assign gotFct    = got_fct_q;
  assign gotTime   = got_time_q;
  assign timeCode  = time_code_q;
  assign errParity = err_parity_q;
  assign errEsc    = err_esc_q;
  assign errDisc   = err_disc_q;
  assign errGlitch = err_glitch_q;
  assign running   = running_q;

endmodule
